// File: rtl/pe_switch_ctx_seq_pkg.sv
// Shared definitions for the PE switch context sequencer.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Contents: selector field geometry, idle switch word, FSM state type and
// the field-legality helpers used when PE_SWITCH_CHECK_EN is defined.
package pe_switch_ctx_seq_pkg;

    localparam int SEL_W = 4;
    localparam int N_SEL = 7;
    localparam logic [SEL_W-1:0] SEL_MAX = 4'd8;

    // Every selector at 4'hF makes the crossbar fall back to its default output.
    localparam logic [SEL_W*N_SEL-1:0] IDLE_SW = '1;

    // Selector field positions inside the switch word (LSB of each field).
    localparam int FLD_LSU_LSB = 24;
    localparam int FLD_A_LSB   = 20;
    localparam int FLD_B_LSB   = 16;
    localparam int FLD_N_LSB   = 12;
    localparam int FLD_S_LSB   = 8;
    localparam int FLD_W_LSB   = 4;
    localparam int FLD_E_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_RUN,
        ST_DONE
    } state_t;

    // Replace every out-of-range selector with the idle code.
    function automatic logic [SEL_W*N_SEL-1:0] sanitize_sw(input logic [SEL_W*N_SEL-1:0] w);
        logic [SEL_W*N_SEL-1:0] r;
        r = w;
        for (int i = 0; i < N_SEL; i++) begin
            if (w[i*SEL_W +: SEL_W] > SEL_MAX) begin
                r[i*SEL_W +: SEL_W] = '1;
            end
        end
        return r;
    endfunction

    // High when any selector field is out of range.
    function automatic logic sw_illegal(input logic [SEL_W*N_SEL-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N_SEL; i++) begin
            if (w[i*SEL_W +: SEL_W] > SEL_MAX) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/pe_switch_ctx_seq_ctx_mem.sv
// Context register file: CTX_DEPTH x SW_W, one sync write, one comb read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the write port is always accepted.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
// Contents are deliberately not reset.
module pe_ctx_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 28
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_switch_ctx_seq.sv
// Loads crossbar switch words over a valid/ready stream and replays them per iteration.
// Latency: start accepted at t -> first context on switch at t+1; done one cycle after last.
// Backpressure: cfg_ready low during RUN/DONE; stall freezes the replay in place.
// Ports: cfg_* load stream, start/run_iters launch, stall, switch/sw_valid to the
// crossbar, busy/done status, ctx_cnt loaded depth, cfg_err sticky error.
// Option: define PE_SWITCH_CHECK_EN to range-check every selector field on load
// (illegal fields stored as 4'hF and flagged in cfg_err).
module pe_switch_ctx_seq
    import pe_switch_ctx_seq_pkg::*;
#(
    parameter int SW_W      = 28,
    parameter int CTX_DEPTH = 8,
    parameter int CTX_AW    = 3,
    parameter int ITER_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SW_W-1:0]   cfg_data,
    input  logic              cfg_last,
    input  logic              start,
    input  logic [ITER_W-1:0] run_iters,
    input  logic              stall,
    output logic [SW_W-1:0]   switch,
    output logic              sw_valid,
    output logic              busy,
    output logic              done,
    output logic [CTX_AW:0]   ctx_cnt,
    output logic              cfg_err
);

    state_t              state_q, state_d;
    logic [CTX_AW-1:0]   wr_ptr;
    logic [CTX_AW-1:0]   rd_ptr;
    logic [ITER_W-1:0]   iters;

    logic                cfg_fire;
    logic                wr_full;
    logic                overflow;
    logic                field_err;
    logic                ctx_last;
    logic                iter_last;
    logic [CTX_AW-1:0]   wr_addr;
    logic [CTX_AW-1:0]   rd_addr;
    logic [SW_W-1:0]     wr_data;
    logic [SW_W-1:0]     rd_data;

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_READY);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign wr_full   = (wr_ptr == CTX_AW'(CTX_DEPTH - 1));
    // A full memory with no cfg_last closes the load and flags the overrun.
    assign overflow  = (state_q == ST_LOAD) && wr_full && !cfg_last;
    assign ctx_last  = (({1'b0, rd_ptr} + (CTX_AW+1)'(1)) == ctx_cnt);
    assign iter_last = (iters == ITER_W'(1));

    // Loads from IDLE/READY always restart at index 0.
    assign wr_addr = (state_q == ST_LOAD) ? wr_ptr : '0;
    // Read address is the context to show on the next edge: 0 at launch or wrap.
    assign rd_addr = (state_q == ST_RUN && !ctx_last) ? rd_ptr + CTX_AW'(1) : '0;

`ifdef PE_SWITCH_CHECK_EN
    assign wr_data   = SW_W'(sanitize_sw(cfg_data));
    assign field_err = sw_illegal(cfg_data);
`else
    assign wr_data   = cfg_data;
    assign field_err = 1'b0;
`endif

    pe_ctx_mem #(
        .DEPTH (CTX_DEPTH),
        .AW    (CTX_AW),
        .W     (SW_W)
    ) u_ctx_mem (
        .clk   (clk),
        .we    (cfg_fire),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_fire) state_d = cfg_last ? ST_READY : ST_LOAD;
            end
            ST_LOAD: begin
                if (cfg_fire && (cfg_last || wr_full)) state_d = ST_READY;
            end
            ST_READY: begin
                // A config beat wins over a simultaneous start.
                if (cfg_fire)   state_d = cfg_last ? ST_READY : ST_LOAD;
                else if (start) state_d = (run_iters == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (!stall && ctx_last && iter_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_READY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            switch   <= SW_W'(IDLE_SW);
            sw_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            iters    <= '0;
            ctx_cnt  <= '0;
            cfg_err  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (cfg_fire && (field_err || overflow)) cfg_err <= 1'b1;

            if (cfg_fire) begin
                if (state_q == ST_LOAD) begin
                    wr_ptr <= wr_ptr + CTX_AW'(1);
                    if (cfg_last || wr_full) ctx_cnt <= {1'b0, wr_ptr} + (CTX_AW+1)'(1);
                end else begin
                    wr_ptr  <= CTX_AW'(1);
                    ctx_cnt <= cfg_last ? (CTX_AW+1)'(1) : '0;
                end
            end

            if (state_q == ST_READY && state_d == ST_RUN) begin
                switch   <= rd_data;
                sw_valid <= 1'b1;
                rd_ptr   <= '0;
                iters    <= run_iters;
            end else if (state_q == ST_RUN && !stall) begin
                if (ctx_last && iter_last) begin
                    switch   <= SW_W'(IDLE_SW);
                    sw_valid <= 1'b0;
                    rd_ptr   <= '0;
                end else begin
                    switch <= rd_data;
                    rd_ptr <= ctx_last ? '0 : rd_ptr + CTX_AW'(1);
                    if (ctx_last) iters <= iters - ITER_W'(1);
                end
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_pe_switch_ctx_seq.sv
// Bench for pe_switch_ctx_seq: directed steps with random words, iterations and stalls,
// checked against an array/queue model of load and replay.
// Honours PE_SWITCH_CHECK_EN the same way the design does.
module tb_pe_switch_ctx_seq;

    localparam logic [27:0] IDLE = 28'hFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [27:0] cfg_data = '0;
    logic        cfg_last = 1'b0;
    logic        start = 1'b0;
    logic [15:0] run_iters = '0;
    logic        stall = 1'b0;
    logic [27:0] sw_out;
    logic        sw_valid;
    logic        busy;
    logic        done;
    logic [3:0]  ctx_cnt;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [27:0] mdl_mem [8];
    int          mdl_cnt = 0;
    bit          mdl_err = 0;
    logic [27:0] wq [$];

    always #5 clk = ~clk;

    pe_switch_ctx_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .start     (start),
        .run_iters (run_iters),
        .stall     (stall),
        .switch    (sw_out),
        .sw_valid  (sw_valid),
        .busy      (busy),
        .done      (done),
        .ctx_cnt   (ctx_cnt),
        .cfg_err   (cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // What the context memory should hold for an incoming word.
    function automatic logic [27:0] mdl_store(input logic [27:0] w, output bit bad);
        logic [27:0] r;
        r   = w;
        bad = 0;
`ifdef PE_SWITCH_CHECK_EN
        for (int f = 0; f < 7; f++) begin
            if (((w >> (4 * f)) & 28'hF) > 28'd8) begin
                r   = r | (28'hF << (4 * f));
                bad = 1;
            end
        end
`endif
        return r;
    endfunction

    // Send the first n words of wq as one load.
    task automatic load(input int n, input bit with_last);
        bit bad;
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = wq[i];
            cfg_last  = with_last && (i == n - 1);
            chk("cfg_ready_load", cfg_ready, 1);
            mdl_mem[i] = mdl_store(wq[i], bad);
            if (bad) mdl_err = 1;
            tick();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        mdl_cnt   = n;
        if (!with_last && n == 8) mdl_err = 1;
        chk("ctx_cnt", ctx_cnt, mdl_cnt);
        chk("cfg_err", cfg_err, mdl_err);
    endtask

    // stall_mode: 0 none, 1 random, 2 exactly two cycles mid-run.
    task automatic run(input int iters, input int stall_mode, input bit cfg_hold);
        logic [27:0] expq [$];
        logic [27:0] gotq [$];
        logic [27:0] prev;
        int  live   = 0;
        int  stalls = 0;
        bit  held   = 0;
        bit  fin    = 0;
        for (int it = 0; it < iters; it++)
            for (int j = 0; j < mdl_cnt; j++) expq.push_back(mdl_mem[j]);

        start     = 1'b1;
        run_iters = 16'(iters);
        tick();
        start = 1'b0;
        if (iters == 0) begin
            chk("zero_done", done, 1);
            chk("zero_valid", sw_valid, 0);
            chk("zero_switch", sw_out, IDLE);
            tick();
            chk("zero_done_clr", done, 0);
            chk("zero_valid2", sw_valid, 0);
            return;
        end
        chk("first_valid", sw_valid, 1);
        chk("busy_run", busy, 1);
        for (int c = 0; c < 2000 && !fin; c++) begin
            if (sw_valid) begin
                live++;
                if (held) chk("stall_hold", sw_out, prev);
                else      gotq.push_back(sw_out);
                prev = sw_out;
                if (cfg_hold) begin
                    chk("cfg_ready_run", cfg_ready, 0);
                    cfg_valid = 1'b1;
                    cfg_data  = 28'($urandom());
                    cfg_last  = 1'($urandom_range(1));
                end
                case (stall_mode)
                    1:       stall = ($urandom_range(3) == 0) && stalls < 4;
                    2:       stall = (live == 2 || live == 3);
                    default: stall = 1'b0;
                endcase
                if (stall) stalls++;
                held = stall;
                tick();
            end else begin
                fin = 1;
            end
        end
        stall = 1'b0;
        if (cfg_hold) chk("cfg_ready_done", cfg_ready, 0);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        if (!fin) chk("run_timeout", 0, 1);
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("switch_idle_end", sw_out, IDLE);
        chk("live_cycles", live, mdl_cnt * iters + stalls);
        chk("seq_len", gotq.size(), expq.size());
        for (int k = 0; k < gotq.size() && k < expq.size(); k++)
            chk($sformatf("seq[%0d]", k), gotq[k], expq[k]);
        tick();
        chk("done_clr", done, 0);
        chk("ctx_cnt_kept", ctx_cnt, mdl_cnt);
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(28'($urandom()));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_switch", sw_out, IDLE);
        chk("rst_valid", sw_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ctx_cnt", ctx_cnt, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cfg_ready", cfg_ready, 1);

        // start in IDLE is ignored
        start = 1'b1;
        run_iters = 16'd1;
        tick();
        start = 1'b0;
        chk("idle_start_busy", busy, 0);
        chk("idle_start_done", done, 0);

        // Three known words, two passes
        wq = '{28'h0123456, 28'h1111111, 28'h8888888};
        load(3, 1);
        run(2, 0, 0);

        // cfg held during a run is never accepted
        run(2, 0, 1);

        // New single-word load overwrites index 0
        rand_words(1);
        load(1, 1);
        run(1 + $urandom_range(2), 0, 0);

        // Zero iterations
        run(0, 0, 0);

        // Two stall cycles mid-run
        wq = '{28'h0123456, 28'h1111111, 28'h8888888};
        load(3, 1);
        run(2, 2, 0);

        // Reset mid-run
        start = 1'b1;
        run_iters = 16'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_cnt = 0;
        mdl_err = 0;
        chk("midrst_switch", sw_out, IDLE);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", sw_valid, 0);
        chk("midrst_ctx_cnt", ctx_cnt, 0);

        // Out-of-range selector field
        wq = '{28'h9000000};
        load(1, 1);
        run(1, 0, 0);

        // Overflow: 8 beats without cfg_last, then a 9th starts a fresh load
        rand_words(8);
        load(8, 0);
        chk("ovf_ready", cfg_ready, 1);
        rand_words(3);
        load(3, 1);
        run(1, 1, 0);

        // Random loads and runs
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_cnt = 0;
        mdl_err = 0;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = 1 + $urandom_range(7);
            rand_words(n);
            load(n, 1);
            run($urandom_range(3), 1, 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
